// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// Runs one iteration per clock on the operand magnitudes. The sign is
// applied once, in the final cycle. It completes WIDTH+1 cycles after start
// is accepted, and emits a single-cycle done pulse with a registered product.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;   // multiplicand magnitude
  logic [WIDTH-1:0]     mplr_q,  mplr_d;    // multiplier, shifts out LSB-first, low product bits shift in
  logic [WIDTH:0]       acc_q,   acc_d;     // upper accumulator with carry bit
  logic [CW-1:0]        cnt_q,   cnt_d;     // iterations remaining
  logic                 neg_q,   neg_d;     // result must be negated
  logic [2*WIDTH-1:0]   p_q,     p_d;
  logic                 done_q,  done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   raw;

  // Operand magnitudes. The most-negative value maps onto 2^(WIDTH-1) unsigned, which still fits.
  always_comb begin
    mag_a = (is_signed && A[WIDTH-1]) ? (~A + ONE_W) : A;
    mag_b = (is_signed && B[WIDTH-1]) ? (~B + ONE_W) : B;
  end

  // Next-state and datapath: latch in IDLE, add/shift in CALC, sign-fix in FINISH.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    done_d  = 1'b0;
    sum     = acc_q;
    raw     = {acc_q[WIDTH-1:0], mplr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          mplr_d  = mag_b;
          neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        // The carry out of the add is kept in acc bit WIDTH, so the shift never loses it.
        if (mplr_q[0]) sum = acc_q + {1'b0, mcand_q};
        acc_d  = {1'b0, sum[WIDTH:1]};
        mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FINISH;
      end
      FINISH: begin
        p_d     = neg_q ? -raw : raw;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule
